// File: rtl/pu_driver_if.sv
// Bundle between the layer-controller stream, the 4-input PU and the result consumer.
// The res_count port exists only when PU_DRV_STATS_EN is defined.
interface pu_driver_if #(
   parameter int DW = 5
) ();
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          w_load;
   logic [1:0]    w_idx;
   logic [DW-1:0] w_data;
   logic [DW-1:0] a1, a2, a3, a4;
   logic [DW-1:0] w1, w2, w3, w4;
   logic [DW-1:0] pu_out;
   logic [DW-1:0] res_data;
   logic          res_valid;
   logic          res_ready;
`ifdef PU_DRV_STATS_EN
   logic [15:0]   res_count;
`endif

   // Driver side.
   modport slave (
`ifdef PU_DRV_STATS_EN
      output res_count,
`endif
      input  in_data, in_valid, w_load, w_idx, w_data, pu_out, res_ready,
      output in_ready, a1, a2, a3, a4, w1, w2, w3, w4, res_data, res_valid
   );

   // Stream producer, PU and result consumer side.
   modport master (
`ifdef PU_DRV_STATS_EN
      input  res_count,
`endif
      output in_data, in_valid, w_load, w_idx, w_data, pu_out, res_ready,
      input  in_ready, a1, a2, a3, a4, w1, w2, w3, w4, res_data, res_valid
   );
endinterface

// File: rtl/pu_driver.sv
// Producer-side sequencer for the 4-input PU: gathers 4 activations, holds weights,
// waits the PU latency and captures the result. Optional result counter: PU_DRV_STATS_EN.
module pu_driver #(
   parameter int DW  = 5,
   parameter int LAT = 2
) (
   input logic       clk,
   input logic       rst,
   pu_driver_if.slave bus
);
   localparam int DLY_W = (LAT < 2) ? 1 : $clog2(LAT + 1);

   typedef enum logic [1:0] {FILL, ISSUE, WAIT, OUT} state_t;

   state_t                state;
   logic [1:0]            cnt;
   logic [DLY_W-1:0]      dly;
   logic                  in_ready_r;
   logic                  res_valid_r;
   logic signed [DW-1:0]  a_r [4];
   logic signed [DW-1:0]  w_r [4];
   logic signed [DW-1:0]  res_data_r;
   logic                  accept;
   logic                  w_wr;

   assign accept = bus.in_valid && in_ready_r;
   // Weights are frozen while a vector is in flight at the PU.
   assign w_wr   = bus.w_load && ((state == FILL) || (state == OUT));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= FILL;
         cnt         <= 2'd0;
         dly         <= '0;
         in_ready_r  <= 1'b1;
         res_valid_r <= 1'b0;
         res_data_r  <= '0;
         for (int i = 0; i < 4; i++) begin
            a_r[i] <= '0;
            w_r[i] <= '0;
         end
      end else begin
         if (w_wr)
            w_r[bus.w_idx] <= bus.w_data;
         case (state)
            FILL: begin
               if (accept) begin
                  a_r[cnt] <= bus.in_data;
                  cnt      <= cnt + 2'd1;
                  if (cnt == 2'd3) begin
                     state      <= ISSUE;
                     in_ready_r <= 1'b0;
                  end
               end
            end
            ISSUE: begin
               dly   <= DLY_W'(LAT);
               state <= WAIT;
            end
            WAIT: begin
               // dly reaches 1 on the edge that ends the PU latency window.
               if (dly == DLY_W'(1)) begin
                  res_data_r  <= bus.pu_out;
                  res_valid_r <= 1'b1;
                  state       <= OUT;
               end else begin
                  dly <= dly - DLY_W'(1);
               end
            end
            OUT: begin
               if (bus.res_ready) begin
                  res_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state       <= FILL;
               end
            end
            default: begin
               state      <= FILL;
               in_ready_r <= 1'b1;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.res_valid = res_valid_r;
   assign bus.res_data  = res_data_r;
   assign bus.a1        = a_r[0];
   assign bus.a2        = a_r[1];
   assign bus.a3        = a_r[2];
   assign bus.a4        = a_r[3];
   assign bus.w1        = w_r[0];
   assign bus.w2        = w_r[1];
   assign bus.w3        = w_r[2];
   assign bus.w4        = w_r[3];

`ifdef PU_DRV_STATS_EN
   logic [15:0] res_count_r;

   always_ff @(posedge clk) begin
      if (!rst)
         res_count_r <= 16'd0;
      else if (res_valid_r && bus.res_ready)
         res_count_r <= res_count_r + 16'd1;
   end

   assign bus.res_count = res_count_r;
`endif
endmodule

// File: tb/tb_pu_driver.sv
// Bench for pu_driver: directed table rows, multi-cycle corner sequences and random
// vectors checked against a transaction-level model of the driver.
module tb_pu_driver;
   localparam int DW  = 5;
   localparam int LAT = 2;

   typedef struct {
      logic [3:0][DW-1:0] s;
      logic [3:0][DW-1:0] fw;
      logic [DW-1:0]      pu;
      int                 stall;
      logic [1:0]         ww_idx;
      logic [DW-1:0]      ww_data;
      logic               ow_en;
      logic [1:0]         ow_idx;
      logic [DW-1:0]      ow_data;
      logic [3:0][DW-1:0] exp_a;
      logic [3:0][DW-1:0] exp_w;
      logic [DW-1:0]      exp_res;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   pu_driver_if #(.DW(DW)) bus ();
   pu_driver #(.DW(DW), .LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;
   logic [DW-1:0] wm [4];
   logic [15:0]   cnt_model = 16'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] dut_a(input int i);
      case (i)
         0: return bus.a1;
         1: return bus.a2;
         2: return bus.a3;
         default: return bus.a4;
      endcase
   endfunction

   function automatic logic [DW-1:0] dut_w(input int i);
      case (i)
         0: return bus.w1;
         1: return bus.w2;
         2: return bus.w3;
         default: return bus.w4;
      endcase
   endfunction

   task automatic check_a(input string tag, input logic [3:0][DW-1:0] exp);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_a%0d", tag, i + 1), dut_a(i), exp[i]);
   endtask

   task automatic check_w(input string tag);
      for (int i = 0; i < 4; i++) chk($sformatf("%s_w%0d", tag, i + 1), dut_w(i), wm[i]);
   endtask

   task automatic idle_inputs();
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.w_load    = 1'b0;
      bus.w_idx     = 2'd0;
      bus.w_data    = '0;
      bus.res_ready = 1'b0;
      bus.pu_out    = '0;
   endtask

   task automatic do_reset(input int n);
      idle_inputs();
      rst = 1'b0;
      for (int k = 0; k < n; k++) tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) wm[i] = '0;
      cnt_model = 16'd0;
   endtask

   // One full transaction: FILL (with optional weight writes and gaps), ISSUE,
   // WAIT (PU result valid only in the last WAIT cycle), OUT with stall cycles.
   task automatic run_vector(
      input logic [3:0][DW-1:0] s,
      input logic [3:0]         fw_en,
      input logic [3:0][1:0]    fw_idx,
      input logic [3:0][DW-1:0] fw_data,
      input int                 gap_max,
      input logic [DW-1:0]      pu,
      input int                 stall,
      input logic [1:0]         ww_idx,
      input logic [DW-1:0]      ww_data,
      input logic               ow_en,
      input logic [1:0]         ow_idx,
      input logic [DW-1:0]      ow_data,
      input logic               hold_en,
      input logic [DW-1:0]      hold_data
   );
      logic [DW-1:0] garb;
      garb = (pu == 5'h1F) ? 5'h00 : 5'h1F;
      for (int i = 0; i < 4; i++) begin
         int g;
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         for (int k = 0; k < g; k++) begin
            bus.in_valid = 1'b0;
            bus.w_load   = 1'b0;
            bus.pu_out   = garb;
            chk("in_ready_gap", bus.in_ready, 1);
            tick();
         end
         bus.in_valid = 1'b1;
         bus.in_data  = s[i];
         bus.w_load   = fw_en[i];
         bus.w_idx    = fw_idx[i];
         bus.w_data   = fw_data[i];
         chk("in_ready_fill", bus.in_ready, 1);
         tick();
         if (fw_en[i]) wm[fw_idx[i]] = fw_data[i];
      end
      // ISSUE: weight writes attempted here and in WAIT must be ignored
      bus.in_valid = hold_en;
      bus.in_data  = hold_data;
      bus.w_load   = 1'b1;
      bus.w_idx    = ww_idx;
      bus.w_data   = ww_data;
      bus.pu_out   = garb;
      chk("in_ready_issue", bus.in_ready, 0);
      chk("res_valid_issue", bus.res_valid, 0);
      check_a("issue", s);
      check_w("issue");
      tick();
      for (int k = 1; k <= LAT; k++) begin
         bus.pu_out = (k == LAT) ? pu : garb;
         chk("in_ready_wait", bus.in_ready, 0);
         chk("res_valid_wait", bus.res_valid, 0);
         check_w("wait");
         tick();
      end
      bus.pu_out = garb;
      for (int c = 0; c <= stall; c++) begin
         bus.res_ready = (c == stall);
         bus.w_load    = ow_en && (c == 0);
         bus.w_idx     = ow_idx;
         bus.w_data    = ow_data;
         chk("res_valid_out", bus.res_valid, 1);
         chk("res_data_out", bus.res_data, pu);
         chk("in_ready_out", bus.in_ready, 0);
         check_a("out", s);
         tick();
         if (ow_en && (c == 0)) wm[ow_idx] = ow_data;
         if (c < stall) check_w("out_after_write");
      end
      bus.res_ready = 1'b0;
      bus.w_load    = 1'b0;
      cnt_model     = cnt_model + 16'd1;
      chk("res_valid_after_hs", bus.res_valid, 0);
      chk("in_ready_after_hs", bus.in_ready, 1);
      check_w("after_hs");
`ifdef PU_DRV_STATS_EN
      chk("res_count", bus.res_count, cnt_model);
`endif
   endtask

   vec_t tbl [3];

   initial begin
      logic [3:0][DW-1:0] s, fd, zero4;
      logic [3:0][1:0]    fi, seq_idx;
      logic [3:0]         fe;
      zero4   = '0;
      seq_idx = {2'd3, 2'd2, 2'd1, 2'd0};

      tbl[0] = '{s: {5'd9, 5'd7, 5'd5, 5'd3}, fw: {5'd4, 5'd3, 5'd2, 5'd1}, pu: 5'h0A,
                 stall: 0, ww_idx: 2'd2, ww_data: 5'd7, ow_en: 1'b0, ow_idx: 2'd0, ow_data: 5'd0,
                 exp_a: {5'd9, 5'd7, 5'd5, 5'd3}, exp_w: {5'd4, 5'd3, 5'd2, 5'd1}, exp_res: 5'h0A};
      tbl[1] = '{s: {5'h00, 5'h1F, 5'h0F, 5'h10}, fw: {5'h0F, 5'h00, 5'h10, 5'h1F}, pu: 5'h10,
                 stall: 2, ww_idx: 2'd2, ww_data: 5'd7, ow_en: 1'b1, ow_idx: 2'd2, ow_data: 5'd7,
                 exp_a: {5'h00, 5'h1F, 5'h0F, 5'h10}, exp_w: {5'h0F, 5'h07, 5'h10, 5'h1F}, exp_res: 5'h10};
      tbl[2] = '{s: {5'h1E, 5'h01, 5'h0A, 5'h15}, fw: {5'd8, 5'd7, 5'd6, 5'd5}, pu: 5'h00,
                 stall: 1, ww_idx: 2'd0, ww_data: 5'h1F, ow_en: 1'b1, ow_idx: 2'd3, ow_data: 5'h11,
                 exp_a: {5'h1E, 5'h01, 5'h0A, 5'h15}, exp_w: {5'h11, 5'd7, 5'd6, 5'd5}, exp_res: 5'h00};

      // Reset held with traffic present
      idle_inputs();
      bus.in_valid = 1'b1;
      bus.in_data  = 5'h15;
      bus.w_load   = 1'b1;
      bus.w_data   = 5'h0A;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) tick();
      check_a("rst", zero4);
      for (int i = 0; i < 4; i++) wm[i] = '0;
      check_w("rst");
      chk("rst_res_data", bus.res_data, 0);
      chk("rst_res_valid", bus.res_valid, 0);
      bus.w_load = 1'b0;
      rst = 1'b1;
      chk("in_ready_release", bus.in_ready, 1);
      tick();
      chk("first_sample_a1", bus.a1, 5'h15);
      chk("first_sample_a2", bus.a2, 0);
      do_reset(1);
      chk("partial_discard_a1", bus.a1, 0);

      // Directed table
      for (int r = 0; r < 3; r++) begin
         run_vector(tbl[r].s, 4'b1111, seq_idx, tbl[r].fw, 0, tbl[r].pu, tbl[r].stall,
                    tbl[r].ww_idx, tbl[r].ww_data, tbl[r].ow_en, tbl[r].ow_idx, tbl[r].ow_data,
                    1'b0, '0);
         for (int i = 0; i < 4; i++) begin
            chk($sformatf("tbl%0d_a%0d", r, i + 1), dut_a(i), tbl[r].exp_a[i]);
            chk($sformatf("tbl%0d_w%0d", r, i + 1), dut_w(i), tbl[r].exp_w[i]);
         end
         chk($sformatf("tbl%0d_res", r), bus.res_data, tbl[r].exp_res);
      end

      // Backpressure with a pending sample that must not be consumed until FILL
      run_vector({5'd4, 5'd3, 5'd2, 5'd1}, 4'b0000, seq_idx, zero4, 0, 5'h06, 5,
                 2'd1, 5'd9, 1'b0, 2'd0, 5'd0, 1'b1, 5'h11);
      chk("bp_a1_before", bus.a1, 5'd1);
      tick();
      chk("bp_a1_captured", bus.a1, 5'h11);
      bus.in_valid = 1'b0;
      do_reset(1);

      // Reset during WAIT: aborted vector never reports
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data  = DW'(i + 20);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.pu_out   = 5'h0C;
      tick();
      tick();
      do_reset(1);
      for (int k = 0; k < LAT + 3; k++) begin
         chk("abort_no_res_valid", bus.res_valid, 0);
         bus.pu_out = 5'h0C;
         tick();
      end
      chk("abort_a1_cleared", bus.a1, 0);
      chk("abort_in_ready", bus.in_ready, 1);
      run_vector({5'h1C, 5'h0B, 5'h02, 5'h17}, 4'b0101, seq_idx, {5'd0, 5'd3, 5'd0, 5'd9}, 0,
                 5'h13, 0, 2'd3, 5'd1, 1'b0, 2'd0, 5'd0, 1'b0, '0);

`ifdef PU_DRV_STATS_EN
      force dut.res_count_r = 16'hFFFF;
      #1;
      release dut.res_count_r;
      cnt_model = 16'hFFFF;
      run_vector({5'd1, 5'd1, 5'd1, 5'd1}, 4'b0000, seq_idx, zero4, 0, 5'h05, 0,
                 2'd0, 5'd0, 1'b0, 2'd0, 5'd0, 1'b0, '0);
      chk("res_count_wrap", bus.res_count, 16'h0000);
`endif

      // Random transactions against the model
      for (int n = 0; n < 30; n++) begin
         for (int i = 0; i < 4; i++) begin
            s[i]  = DW'($urandom);
            fd[i] = DW'($urandom);
            fi[i] = 2'($urandom);
            fe[i] = 1'($urandom);
         end
         run_vector(s, fe, fi, fd, 2, DW'($urandom), int'($urandom_range(3, 0)),
                    2'($urandom), DW'($urandom), 1'($urandom), 2'($urandom), DW'($urandom),
                    1'b0, '0);
         check_a("rand_final", s);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "simulation time limit");
   end
endmodule
